// File: rtl/sample_mixer_dac_pkg.sv
// Shared audio constants and the saturating two-sample adder used by the mixer.
package sample_mixer_dac_pkg;
   localparam int SAMPLE_W    = 16;
   localparam int FRAME_SLOTS = 32;
   localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [SAMPLE_W-1:0] SAT_MIN = 16'h8000;

   // Returns {saturated_sum, clip}; overflow shows as disagreement of the two top sum bits.
   function automatic logic [SAMPLE_W:0] sat_add16(input logic [SAMPLE_W-1:0] a,
                                                   input logic [SAMPLE_W-1:0] b);
      logic [SAMPLE_W:0] s;
      s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
      if (s[SAMPLE_W] != s[SAMPLE_W-1])
         return s[SAMPLE_W] ? {SAT_MIN, 1'b1} : {SAT_MAX, 1'b1};
      return {s[SAMPLE_W-1:0], 1'b0};
   endfunction
endpackage

// File: rtl/sample_mixer_dac_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF system clocks and flags the 1->0 edge.
module bclk_gen #(
   parameter int BCLK_HALF = 4
) (
   input  logic clock,
   input  logic reset,
   output logic bclk,
   output logic falling_tick
);
   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

   logic [DIV_W-1:0] div;
   logic             wrap;

   assign wrap         = (div == DIV_LAST);
   assign falling_tick = wrap && bclk;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div  <= '0;
         bclk <= 1'b0;
      end else if (wrap) begin
         div  <= '0;
         bclk <= ~bclk;
      end else begin
         div  <= div + 1'b1;
      end
   end
endmodule

// File: rtl/sample_mixer_dac.sv
// Saturating two-channel mixer feeding a left-justified mono serial DAC link.
module sample_mixer_dac
   import sample_mixer_dac_pkg::*;
#(
   parameter int BCLK_HALF = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample0,
   input  logic [SAMPLE_W-1:0] sample1,
   input  logic                mute,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                sample_req,
   output logic                clip
);
   localparam int SLOT_W = $clog2(FRAME_SLOTS);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_SLOTS - 1);
   localparam logic [SLOT_W-1:0] SLOT_MID  = SLOT_W'(FRAME_SLOTS / 2 - 1);

   logic                falling_tick;
   logic [SLOT_W-1:0]   slot;
   logic [SLOT_W-1:0]   slot_next;
   logic [SAMPLE_W-1:0] shift_reg;
   logic [SAMPLE_W-1:0] hold_reg;
   logic [SAMPLE_W:0]   mix;

   bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
      .clock        (clock),
      .reset        (reset),
      .bclk         (bclk),
      .falling_tick (falling_tick)
   );

   assign slot_next = slot + 1'b1;
   assign mix       = sat_add16(sample0, sample1);
   assign sdata     = shift_reg[SAMPLE_W-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot       <= SLOT_LAST;
         shift_reg  <= '0;
         hold_reg   <= '0;
         lrclk      <= 1'b0;
         clip       <= 1'b0;
         sample_req <= 1'b0;
      end else begin
         sample_req <= 1'b0;
         if (falling_tick) begin
            slot  <= slot_next;
            lrclk <= ~slot_next[SLOT_W-1];
            if (slot == SLOT_LAST) begin
               sample_req <= 1'b1;
               if (mute) begin
                  hold_reg  <= '0;
                  shift_reg <= '0;
                  clip      <= 1'b0;
               end else begin
                  hold_reg  <= mix[SAMPLE_W:1];
                  shift_reg <= mix[SAMPLE_W:1];
                  clip      <= mix[0];
               end
            end else if (slot == SLOT_MID) begin
               // Right half repeats the held word so the link carries mono.
               shift_reg <= hold_reg;
            end else begin
               shift_reg <= {shift_reg[SAMPLE_W-2:0], 1'b0};
            end
         end
      end
   end
endmodule

// File: tb/tb_sample_mixer_dac.sv
// Directed bench for sample_mixer_dac with BCLK_HALF=2 (4 clocks per slot, 128 per frame).
module tb_sample_mixer_dac;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] sample0 = '0;
   logic [15:0] sample1 = '0;
   logic        mute = 1'b0;
   logic        bclk, lrclk, sdata, sample_req, clip;

   int total = 0;
   int bad   = 0;

   sample_mixer_dac #(.BCLK_HALF(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .sample0    (sample0),
      .sample1    (sample1),
      .mute       (mute),
      .bclk       (bclk),
      .lrclk      (lrclk),
      .sdata      (sdata),
      .sample_req (sample_req),
      .clip       (clip)
   );

   always #5 clock = ~clock;

   // Waits (bounded) for the next frame load, then records all 32 slots.
   // At slot chg_slot (if >= 0) mute is raised and saturating inputs applied mid-frame.
   task automatic do_frame(input int chg_slot, output bit ok,
                           output logic [31:0] bits, output logic [31:0] lr,
                           output logic [31:0] cl);
      ok = 0; bits = '0; lr = '0; cl = '0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clock); #1;
         if (sample_req) begin ok = 1; break; end
      end
      if (!ok) return;
      for (int k = 0; k < 32; k++) begin
         bits[31-k] = sdata;
         lr[31-k]   = lrclk;
         cl[31-k]   = clip;
         if (k == chg_slot) begin
            mute = 1'b1; sample0 = 16'h7000; sample1 = 16'h2000;
         end
         if (k < 31) begin
            repeat (4) @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic check_startup(input string tag);
      int n;
      @(negedge clock);
      reset = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clock); #1;
         total++;
         if (sample_req !== (e == 4)) begin
            bad++;
            $display("FAIL %s req_edge%0d: sample_req=%b want %b", tag, e, sample_req, (e == 4));
         end
         if (e == 2) begin
            total++;
            if (bclk !== 1'b1) begin
               bad++; $display("FAIL %s bclk_edge2: got %b want 1", tag, bclk);
            end
         end
      end
      total++;
      if (lrclk !== 1'b1) begin
         bad++; $display("FAIL %s lrclk_first: got %b want 1", tag, lrclk);
      end
      n = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clock); #1; n++;
         if (sample_req) break;
      end
      total++;
      if (n !== 128) begin
         bad++; $display("FAIL %s req_period: got %0d clocks want 128", tag, n);
      end
   endtask

   task automatic test_reset();
      #23;
      total++;
      if ({bclk, lrclk, sdata, sample_req, clip} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 00000", {bclk, lrclk, sdata, sample_req, clip});
      end
      check_startup("reset");
   endtask

   task automatic test_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] word, input logic clip_exp);
      bit ok; logic [31:0] bits, lr, cl;
      sample0 = a; sample1 = b;
      do_frame(-1, ok, bits, lr, cl);
      total++;
      if (!ok) begin
         bad++; $display("FAIL %s timeout: no sample_req within 300 clocks", tag);
         return;
      end
      total++;
      if (bits !== {word, word}) begin
         bad++; $display("FAIL %s data: got %h want %h", tag, bits, {word, word});
      end
      total++;
      if (lr !== 32'hFFFF_0000) begin
         bad++; $display("FAIL %s lrclk: got %h want ffff0000", tag, lr);
      end
      total++;
      if (cl !== {32{clip_exp}}) begin
         bad++; $display("FAIL %s clip: got %h want %h", tag, cl, {32{clip_exp}});
      end
   endtask

   task automatic test_mute();
      bit ok; logic [31:0] bits, lr, cl;
      sample0 = 16'h0100; sample1 = 16'h0200;
      do_frame(8, ok, bits, lr, cl);
      total++;
      if (!ok || bits !== 32'h0300_0300 || cl !== 32'h0) begin
         bad++;
         $display("FAIL mute_curframe: ok=%b data=%h clip=%h want data=03000300 clip=0", ok, bits, cl);
      end
      do_frame(-1, ok, bits, lr, cl);
      total++;
      if (!ok || bits !== 32'h0 || cl !== 32'h0) begin
         bad++;
         $display("FAIL mute_next: ok=%b data=%h clip=%h want 0 0", ok, bits, cl);
      end
      mute = 1'b0;
   endtask

   task automatic test_reset_midframe();
      bit ok;
      sample0 = 16'h7000; sample1 = 16'h2000;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clock); #1;
         if (sample_req) begin ok = 1; break; end
      end
      total++;
      if (!ok) begin
         bad++; $display("FAIL rst_mid timeout: no sample_req"); return;
      end
      // Land in slot 20 with bclk high: word 0x7FFF puts a 1 on sdata here.
      repeat (82) @(posedge clock);
      #1;
      total++;
      if ({bclk, lrclk, sdata, clip} !== 4'b1011) begin
         bad++; $display("FAIL rst_mid_before: got %b want 1011", {bclk, lrclk, sdata, clip});
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if ({bclk, lrclk, sdata, sample_req, clip} !== 5'b0) begin
         bad++;
         $display("FAIL rst_mid_async: got %b want 00000", {bclk, lrclk, sdata, sample_req, clip});
      end
      repeat (3) @(posedge clock);
      check_startup("rst_mid");
   endtask

   initial begin
      test_reset();
      test_frame("mix",     16'h1234, 16'h0100, 16'h1334, 1'b0);
      test_frame("pos_sat", 16'h7000, 16'h2000, 16'h7FFF, 1'b1);
      test_frame("small",   16'h0001, 16'h0001, 16'h0002, 1'b0);
      test_frame("neg_sat", 16'h8000, 16'hFFFF, 16'h8000, 1'b1);
      test_frame("neg_ok",  16'h8000, 16'h0001, 16'h8001, 1'b0);
      test_mute();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
